// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch I, data stage D) onto one shared memory port.
// Define MEM_ARBITER_ROUND_ROBIN_EN to alternate tie winners; otherwise D always wins ties.
module mem_arbiter #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_read,
  input  logic [DATA_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [1:0]        d_wmask,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [DATA_W-1:0] pmem_addr,
  output logic [DATA_W-1:0] pmem_wdata,
  output logic [1:0]        pmem_wmask,
  input  logic [DATA_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} stateT;

  stateT stateReg;
  logic  iPending;
  logic  dPending;
  logic  grantD;

  assign iPending = i_read;
  assign dPending = d_read | d_write;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic lastGrantDReg;  // 1 when D received the most recent grant
  assign grantD = dPending & (~iPending | ~lastGrantDReg);
`else
  assign grantD = dPending;
`endif

  // Responses are only meaningful to the current owner; a stray pmem_resp in IDLE is dropped.
  assign i_resp  = pmem_resp & (stateReg == I_BUSY);
  assign d_resp  = pmem_resp & (stateReg == D_BUSY);
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg   <= IDLE;
      pmem_read  <= 1'b0;
      pmem_write <= 1'b0;
      pmem_addr  <= '0;
      pmem_wdata <= '0;
      pmem_wmask <= '0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      lastGrantDReg <= 1'b0;
`endif
    end else begin
      case (stateReg)
        IDLE: begin
          if (iPending | dPending) begin
            if (grantD) begin
              stateReg   <= D_BUSY;
              pmem_read  <= d_read & ~d_write;
              pmem_write <= d_write;
              pmem_addr  <= d_addr;
              pmem_wdata <= d_wdata;
              pmem_wmask <= d_wmask;
            end else begin
              stateReg   <= I_BUSY;
              pmem_read  <= 1'b1;
              pmem_write <= 1'b0;
              pmem_addr  <= i_addr;
              pmem_wdata <= '0;
              pmem_wmask <= '0;
            end
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            lastGrantDReg <= grantD;
`endif
          end
        end
        I_BUSY, D_BUSY: begin
          // Strobes are held from the grant so a requester dropping early cannot cut the access short.
          if (pmem_resp) begin
            stateReg   <= IDLE;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            pmem_addr  <= '0;
            pmem_wdata <= '0;
            pmem_wmask <= '0;
          end
        end
        default: stateReg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written corner sequences,
// then randomized protocol-compliant traffic against a transaction-level ownership model.
module tb_mem_arbiter;
  localparam int W = 16;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_read = 1'b0, d_read = 1'b0, d_write = 1'b0, pmem_resp = 1'b0;
  logic [W-1:0]  i_addr = '0, d_addr = '0, d_wdata = '0, pmem_rdata = '0;
  logic [1:0]    d_wmask = '0;
  logic [W-1:0]  i_rdata, d_rdata, pmem_addr, pmem_wdata;
  logic          i_resp, d_resp, pmem_read, pmem_write;
  logic [1:0]    pmem_wmask;

  mem_arbiter #(.DATA_W(W)) dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wmask(d_wmask), .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
    .pmem_wdata(pmem_wdata), .pmem_wmask(pmem_wmask), .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic rst, ir; logic [W-1:0] ia;
    logic dr, dw; logic [W-1:0] da, dwd; logic [1:0] dm;
    logic pr; logic [W-1:0] prd;
    logic eRd, eWr; logic [W-1:0] eAddr, eWd; logic [1:0] eMask;
    logic eIr, eDr;
  } vecT;

  localparam int NV = 32;
  vecT vecs [NV];

  function automatic vecT v(input logic rst, ir, input logic [W-1:0] ia,
                            input logic dr, dw, input logic [W-1:0] da, dwd,
                            input logic [1:0] dm, input logic pr, input logic [W-1:0] prd,
                            input logic eRd, eWr, input logic [W-1:0] eAddr, eWd,
                            input logic [1:0] eMask, input logic eIr, eDr);
    vecT r;
    r = '{rst, ir, ia, dr, dw, da, dwd, dm, pr, prd, eRd, eWr, eAddr, eWd, eMask, eIr, eDr};
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    reset = 1'b0; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; pmem_resp = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_wmask = '0; pmem_rdata = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // Random-phase model state: owner 0 = none, 1 = I, 2 = D
  int   owner, busyCnt, lat, txn, kind;
  bit   lastD, iDone, dDone, care;
  logic eRd, eWr;
  logic [W-1:0] eAddr, eWd;
  logic [1:0] eMask;

  initial begin
    //   rst ir ia        dr dw da        dwd       dm     pr prd        eRd eWr eAddr    eWd       eMask  eIr eDr
    vecs[0]  = v(1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 0);
    vecs[1]  = v(0, 1, 16'h3000, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 0);
    vecs[2]  = v(0, 1, 16'h3000, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 16'h0000, 1, 0, 16'h3000, 16'h0000, 2'b00, 0, 0);
    vecs[3]  = v(0, 1, 16'h3000, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 16'h0000, 1, 0, 16'h3000, 16'h0000, 2'b00, 0, 0);
    vecs[4]  = v(0, 1, 16'h3000, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 16'h0000, 1, 0, 16'h3000, 16'h0000, 2'b00, 0, 0);
    vecs[5]  = v(0, 1, 16'h3000, 0, 0, 16'h0000, 16'h0000, 2'b00, 1, 16'h1234, 1, 0, 16'h3000, 16'h0000, 2'b00, 1, 0);
    vecs[6]  = v(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 0);
    vecs[7]  = v(0, 0, 16'h0000, 0, 1, 16'h4001, 16'hAB00, 2'b10, 1, 16'h5555, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 0);
    vecs[8]  = v(0, 0, 16'h0000, 0, 1, 16'h4001, 16'hAB00, 2'b10, 0, 16'h0000, 0, 1, 16'h4001, 16'hAB00, 2'b10, 0, 0);
    vecs[9]  = v(0, 0, 16'h0000, 0, 1, 16'h4001, 16'hAB00, 2'b10, 1, 16'h0F0F, 0, 1, 16'h4001, 16'hAB00, 2'b10, 0, 1);
    vecs[10] = v(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 0);
    vecs[11] = v(0, 1, 16'h1111, 1, 0, 16'h2222, 16'h0000, 2'b11, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 0);
    vecs[12] = v(0, 1, 16'h1111, 1, 0, 16'h2222, 16'h0000, 2'b11, 0, 16'h0000, 1, 0, 16'h2222, 16'h0000, 2'b11, 0, 0);
    vecs[13] = v(0, 1, 16'h1111, 1, 0, 16'h2222, 16'h0000, 2'b11, 1, 16'hBEEF, 1, 0, 16'h2222, 16'h0000, 2'b11, 0, 1);
    vecs[14] = v(0, 1, 16'h1111, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 0);
    vecs[15] = v(0, 1, 16'h1111, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 16'h0000, 1, 0, 16'h1111, 16'h0000, 2'b00, 0, 0);
    vecs[16] = v(0, 1, 16'h1111, 0, 0, 16'h0000, 16'h0000, 2'b00, 1, 16'h4321, 1, 0, 16'h1111, 16'h0000, 2'b00, 1, 0);
    vecs[17] = v(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 0);
    vecs[18] = v(0, 0, 16'h0000, 1, 0, 16'h0050, 16'h0000, 2'b00, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 0);
    vecs[19] = v(0, 0, 16'h0000, 1, 0, 16'h0050, 16'h0000, 2'b00, 0, 16'h0000, 1, 0, 16'h0050, 16'h0000, 2'b00, 0, 0);
    vecs[20] = v(1, 0, 16'h0000, 1, 0, 16'h0050, 16'h0000, 2'b00, 0, 16'h0000, 1, 0, 16'h0050, 16'h0000, 2'b00, 0, 0);
    vecs[21] = v(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 2'b00, 1, 16'h7777, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 0);
    vecs[22] = v(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 0);
    vecs[23] = v(0, 1, 16'h0A0A, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 0);
    vecs[24] = v(0, 1, 16'h0A0A, 1, 0, 16'h0B0B, 16'h0000, 2'b00, 0, 16'h0000, 1, 0, 16'h0A0A, 16'h0000, 2'b00, 0, 0);
    vecs[25] = v(0, 1, 16'h0A0A, 1, 0, 16'h0B0B, 16'h0000, 2'b00, 0, 16'h0000, 1, 0, 16'h0A0A, 16'h0000, 2'b00, 0, 0);
    vecs[26] = v(0, 1, 16'h0A0A, 1, 0, 16'h0B0B, 16'h0000, 2'b00, 0, 16'h0000, 1, 0, 16'h0A0A, 16'h0000, 2'b00, 0, 0);
    vecs[27] = v(0, 1, 16'h0A0A, 1, 0, 16'h0B0B, 16'h0000, 2'b00, 1, 16'h0001, 1, 0, 16'h0A0A, 16'h0000, 2'b00, 1, 0);
    vecs[28] = v(0, 0, 16'h0000, 1, 0, 16'h0B0B, 16'h0000, 2'b00, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 0);
    vecs[29] = v(0, 0, 16'h0000, 1, 0, 16'h0B0B, 16'h0000, 2'b00, 0, 16'h0000, 1, 0, 16'h0B0B, 16'h0000, 2'b00, 0, 0);
    vecs[30] = v(0, 0, 16'h0000, 1, 0, 16'h0B0B, 16'h0000, 2'b00, 1, 16'h2468, 1, 0, 16'h0B0B, 16'h0000, 2'b00, 0, 1);
    vecs[31] = v(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 2'b00, 0, 0);

    reset = 1'b1;
    cyc();
    cyc();

    // Directed table: one row per clock cycle
    for (int k = 0; k < NV; k++) begin
      reset = vecs[k].rst; i_read = vecs[k].ir; i_addr = vecs[k].ia;
      d_read = vecs[k].dr; d_write = vecs[k].dw; d_addr = vecs[k].da;
      d_wdata = vecs[k].dwd; d_wmask = vecs[k].dm;
      pmem_resp = vecs[k].pr; pmem_rdata = vecs[k].prd;
      @(negedge clk);
      // wdata/wmask are only defined for D ownership and IDLE
      care = !(vecs[k].ir && vecs[k].eRd && !vecs[k].eWr && vecs[k].eAddr == vecs[k].ia);
      chk($sformatf("vec%0d_pmem", k),
          64'({pmem_read, pmem_write, pmem_addr, care ? pmem_wdata : 16'h0, care ? pmem_wmask : 2'b00}),
          64'({vecs[k].eRd, vecs[k].eWr, vecs[k].eAddr, care ? vecs[k].eWd : 16'h0, care ? vecs[k].eMask : 2'b00}));
      chk($sformatf("vec%0d_resp", k), 64'({i_resp, d_resp}), 64'({vecs[k].eIr, vecs[k].eDr}));
      chk($sformatf("vec%0d_rdata", k), 64'({i_rdata, d_rdata}), 64'({vecs[k].prd, vecs[k].prd}));
      $display("vec %0d: rd=%0b wr=%0b addr=%h i_resp=%0b d_resp=%0b", k, pmem_read, pmem_write,
               pmem_addr, i_resp, d_resp);
      cyc();
    end

    // Request dropped mid-grant: the grant stays until pmem_resp
    clearInputs();
    i_read = 1'b1; i_addr = 16'h0123;
    @(negedge clk); chk("drop_idle", 64'(pmem_read), 64'(1'b0));
    cyc();
    @(negedge clk); chk("drop_grant", 64'({pmem_read, pmem_addr}), 64'({1'b1, 16'h0123}));
    cyc(); i_read = 1'b0; i_addr = '0;
    @(negedge clk); chk("drop_hold", 64'(pmem_read), 64'(1'b1));
    cyc(); pmem_resp = 1'b1; pmem_rdata = 16'h9999;
    @(negedge clk); chk("drop_resp", 64'({i_resp, d_resp}), 64'(2'b10));
    cyc(); pmem_resp = 1'b0;
    @(negedge clk); chk("drop_end", 64'(pmem_read), 64'(1'b0));
    $display("seq drop: grant held after request dropped");

    // Back-to-back ties after reset: D first always, second tie depends on mode
    reset = 1'b1; cyc(); reset = 1'b0;
    i_read = 1'b1; i_addr = 16'h1111; d_read = 1'b1; d_addr = 16'h2222;
    @(negedge clk); chk("tie2_idle", 64'(pmem_read), 64'(1'b0));
    cyc();
    @(negedge clk); chk("tie2_first", 64'(pmem_addr), 64'(16'h2222));
    cyc(); pmem_resp = 1'b1;
    @(negedge clk); chk("tie2_first_resp", 64'({i_resp, d_resp}), 64'(2'b01));
    cyc(); pmem_resp = 1'b0;
    @(negedge clk); chk("tie2_gap", 64'(pmem_read), 64'(1'b0));
    cyc();
    @(negedge clk); chk("tie2_second", 64'(pmem_addr), 64'(RR ? 16'h1111 : 16'h2222));
    cyc(); pmem_resp = 1'b1;
    @(negedge clk); chk("tie2_second_resp", 64'({i_resp, d_resp}), 64'(RR ? 2'b10 : 2'b01));
    cyc();
    clearInputs();
    $display("seq tie2: second tie winner %s", RR ? "I" : "D");

    // Randomized traffic against the ownership model
    reset = 1'b1; cyc(); reset = 1'b0;
    owner = 0; lastD = 1'b0; busyCnt = 0; lat = 0; txn = 0;
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      eRd   = (owner == 1) || (owner == 2 && d_read && !d_write);
      eWr   = (owner == 2) && d_write;
      eAddr = (owner == 1) ? i_addr : (owner == 2) ? d_addr : 16'h0;
      eWd   = (owner == 2) ? d_wdata : 16'h0;
      eMask = (owner == 2) ? d_wmask : 2'b00;
      care  = (owner != 1);
      chk($sformatf("rnd%0d_pmem", c),
          64'({pmem_read, pmem_write, pmem_addr, care ? pmem_wdata : 16'h0, care ? pmem_wmask : 2'b00}),
          64'({eRd, eWr, eAddr, eWd, eMask}));
      chk($sformatf("rnd%0d_resp", c), 64'({i_resp, d_resp}),
          64'({pmem_resp && owner == 1, pmem_resp && owner == 2}));
      chk($sformatf("rnd%0d_rdata", c), 64'({i_rdata, d_rdata}), 64'({pmem_rdata, pmem_rdata}));

      @(posedge clk);
      iDone = (owner == 1) && pmem_resp;
      dDone = (owner == 2) && pmem_resp;
      if (iDone || dDone) begin
        txn++;
        $display("txn %0d: %s addr=%h rdata=%h", txn, iDone ? "I read" : (d_write ? "D write" : "D read"),
                 iDone ? i_addr : d_addr, pmem_rdata);
      end
      if (reset) begin
        owner = 0; lastD = 1'b0;
      end else if (owner == 0) begin
        if (i_read && (d_read || d_write)) owner = (!RR || !lastD) ? 2 : 1;
        else if (i_read) owner = 1;
        else if (d_read || d_write) owner = 2;
        if (owner != 0) begin
          lastD = (owner == 2); busyCnt = 0; lat = $urandom_range(0, 4);
        end
      end else if (pmem_resp) begin
        owner = 0;
      end else begin
        busyCnt++;
      end
      #1;
      reset = ($urandom_range(0, 149) == 0);
      if (iDone) i_read = 1'b0;
      else if (!i_read && $urandom_range(0, 3) == 0) begin
        i_read = 1'b1; i_addr = 16'($urandom);
      end
      if (dDone) begin
        d_read = 1'b0; d_write = 1'b0;
      end else if (!(d_read || d_write) && $urandom_range(0, 3) == 0) begin
        kind = $urandom_range(0, 2);
        d_read = (kind != 1); d_write = (kind != 0);
        d_addr = 16'($urandom); d_wdata = 16'($urandom); d_wmask = 2'($urandom);
      end
      pmem_rdata = 16'($urandom);
      pmem_resp  = (owner != 0) ? (busyCnt == lat) : ($urandom_range(0, 7) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: DATA_W, 16, width of the address, read data and write data buses.
REQ-002 Ports: clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 Ports: reset  in  1  synchronous, active-high reset.
REQ-004 Ports: i_read  in  1  instruction-fetch read request; i_addr  in  DATA_W  fetch address.
REQ-005 Ports: i_rdata  out  DATA_W  fetch read data; i_resp  out  1  fetch completion pulse.
REQ-006 Ports: d_read, d_write  in  1 each  data-stage read and write requests; d_addr  in  DATA_W  data address.
REQ-007 Ports: d_wdata  in  DATA_W  store data; d_wmask  in  2  byte enables for STB/STW.
REQ-008 Ports: d_rdata  out  DATA_W  data read data; d_resp  out  1  data completion pulse.
REQ-009 Ports: pmem_read, pmem_write  out  1 each  shared memory strobes; pmem_addr, pmem_wdata  out  DATA_W  shared address and write data.
REQ-010 Ports: pmem_wmask  out  2  shared byte enables; pmem_rdata  in  DATA_W  shared read data; pmem_resp  in  1  shared completion.

Function
REQ-011 The FSM SHALL have three states: IDLE, I_BUSY and D_BUSY.
REQ-012 In IDLE, pmem_read and pmem_write SHALL be 0, and pmem_addr, pmem_wdata and pmem_wmask SHALL be 0.
REQ-013 In IDLE with a pending request (i_read, or d_read|d_write), the FSM SHALL move to the granted BUSY state on the next edge, so the pmem strobe asserts exactly 1 cycle after the request is first seen.
REQ-014 In I_BUSY, the block SHALL drive pmem_read=1, pmem_write=0 and pmem_addr=i_addr.
REQ-015 In D_BUSY, the block SHALL drive pmem_read=d_read&~d_write, pmem_write=d_write, pmem_addr=d_addr, pmem_wdata=d_wdata and pmem_wmask=d_wmask.
REQ-016 If d_read and d_write are both 1, the access SHALL be treated as a write.
REQ-017 pmem_resp in a BUSY state SHALL be forwarded combinationally, in the same cycle, to the granted requester's resp output only; the other resp SHALL stay 0.
REQ-018 pmem_rdata SHALL pass combinationally to both i_rdata and d_rdata; only the resp pulse qualifies it.
REQ-019 On pmem_resp, the FSM SHALL return to IDLE on the next edge; at least one IDLE cycle SHALL separate consecutive grants.
REQ-020 pmem_resp received in IDLE SHALL be ignored and SHALL NOT generate i_resp or d_resp.
REQ-021 Requesters hold their request until their resp; if a request drops mid-grant, the grant SHALL remain until pmem_resp.
REQ-022 Arbitration SHALL occur only in IDLE; a request arriving during a grant SHALL wait, with no preemption.
REQ-023 When exactly one requester is pending in IDLE, it SHALL be granted regardless of priority mode.
REQ-024 The FSM SHALL tolerate an arbitrary number of cycles between grant and pmem_resp, with no timeout.

Reset
REQ-025 reset=1 SHALL force IDLE on the next edge, from any state, including mid-transaction.
REQ-026 After reset, all outputs SHALL be 0, and any pmem_resp arriving afterwards SHALL be ignored per REQ-020.
REQ-027 reset SHALL set the last_grant register to I, so that D wins the first tie.

Configuration
REQ-028 Macro MEM_ARBITER_ROUND_ROBIN_EN defined: on a tie in IDLE, the requester not recorded in last_grant SHALL win, and last_grant SHALL update on every grant.
REQ-029 Macro MEM_ARBITER_ROUND_ROBIN_EN undefined: on a tie, D SHALL always win, and the last_grant register SHALL be absent.

Verification
REQ-030 Scenario: i_read=1, i_addr=0x3000, pmem_resp 3 cycles after pmem_read with pmem_rdata=0x1234 -> pmem_read high 1 cycle after the request; i_resp=1 and i_rdata=0x1234 in the resp cycle; d_resp=0.
REQ-031 Scenario: d_write=1, d_addr=0x4001, d_wdata=0xAB00, d_wmask=2'b10 -> pmem_write=1 with those values mirrored; d_resp pulses once; return to IDLE.
REQ-032 Scenario: i_read and d_read asserted in the same cycle after reset -> D granted first, then I after one IDLE cycle, in both macro modes; with MEM_ARBITER_ROUND_ROBIN_EN defined, a second simultaneous tie grants I first.
REQ-033 Scenario: reset asserted in D_BUSY before pmem_resp, then pmem_resp pulses after reset -> strobes 0, no d_resp, FSM in IDLE.
REQ-034 Scenario: d_read raised while I_BUSY, held 5 cycles -> no preemption; D granted 1 cycle after the IDLE that follows i_resp.
